issue_queue: RTL and testbench
==============================

Name: issue_queue

Overview:
- In-order, 2-wide circular instruction buffer between decode and the two FU execute slots of the superscalar in-order pipeline.
- Accepts up to two decoded instructions per cycle and presents the two oldest entries to issue.
- Retires 0–2 entries per cycle as issue consumes them.
- Provides a free-slot indication upstream and a flush for branch/exception redirect.

Parameters:
- DEPTH, 8, number of entries; power of two, ≥4.
- DATA_W, $bits(issue_data_t), width of one entry payload.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- flush  input  1  discard all entries (redirect)
- in_valid  input  2  enqueue lane valids; lane0 is older
- in_data0  input  DATA_W  lane0 payload
- in_data1  input  DATA_W  lane1 payload
- in_ready  output  1  queue can accept two entries this cycle
- out_valid  output  2  bit0: head valid; bit1: head+1 valid
- out_data0  output  DATA_W  head entry
- out_data1  output  DATA_W  entry after head
- issue_take  input  2  consumer retires entries this cycle
- count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Clock/reset: single clock clk; reset asynchronous, active-high.
- On reset:
  - head, tail, count = 0; out_valid = 2'b00; in_ready = 1.
  - Entry storage is not reset.
- Storage: DEPTH entries, read at head, written at tail. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
- Outputs, combinational from registered state only:
  - out_valid[0] = (count≥1); out_valid[1] = (count≥2).
  - out_data0 = mem[head]; out_data1 = mem[head+1 mod DEPTH].
  - Data on an invalid lane is don't-care.
  - in_ready = (DEPTH − count ≥ 2), from start-of-cycle count. It does not credit same-cycle dequeues.
- Enqueue, only when in_ready=1:
  - 2'b01: write in_data0 at tail; tail += 1.
  - 2'b11: write in_data0 at tail, in_data1 at tail+1; tail += 2.
  - 2'b10: write in_data1 at tail; tail += 1 (packed; no hole).
  - in_valid while in_ready=0: ignored, nothing written; upstream must hold.
- Dequeue (effective take n_deq):
  - n_deq = 0 if !issue_take[0] or !out_valid[0].
  - n_deq = 2 if issue_take[1] & out_valid[1].
  - n_deq = 1 otherwise.
  - issue_take[1] without issue_take[0] → 0; issue is strictly in order.
  - head += n_deq.
- count_next = count + n_enq − n_deq. Enqueue and dequeue in the same cycle are legal, including at full/empty.
- Latency:
  - An enqueued entry becomes visible on out_* the following cycle.
  - No same-cycle pass-through when empty.
- Flush:
  - Synchronous. Next cycle head = tail = count = 0.
  - Overrides enqueue and dequeue in the same cycle; same-cycle in_valid entries are dropped.
- Reset mid-operation: asynchronous clear regardless of flush, in_valid or issue_take.
- Full boundary:
  - count=DEPTH−1 → in_ready=0, so single enqueues are also refused.
  - Keeps the upstream 2-wide decode from splitting a bundle.
- Empty boundary: count=0 → out_valid=0; issue_take ignored.
- Assertions (sim only): count ≤ DEPTH; count never underflows.

Test Plan:
- Reset, then enqueue 2'b11 with data A=0x11, B=0x22 → next cycle out_valid=2'b11, out_data0=0x11, out_data1=0x22, count=2.
- Fill DEPTH=8 with 0x01..0x08, two per cycle, no take:
  - After 3 cycles count=6, in_ready=1; after 4 cycles count=8, in_ready=0.
  - in_valid=2'b11 with 0x99 is ignored and count stays 8.
- Wrap-around:
  - Keep 6 entries, then alternate take 2'b11 and enqueue 2'b11 for 10 cycles.
  - Entries leave in exact insertion order across the pointer wrap (tail passes index 7→0).
  - count stays 6.
- Partial issue:
  - Queue holds 0xA,0xB,0xC; issue_take=2'b01 → next cycle out_data0=0xB, count=2.
  - issue_take=2'b10 → no change.
  - issue_take=2'b11 with count=1 → count=0.
- Flush:
  - count=5, with same-cycle in_valid=2'b11 and issue_take=2'b11, flush=1.
  - Next cycle count=0, out_valid=0, in_ready=1; a later enqueue of 0x55 appears at out_data0.
- Async reset:
  - Assert reset mid-cycle with count=4.
  - out_valid falls to 0 immediately, without waiting for clk, and count=0 after release.

Source files
------------

// File: rtl/issue_queue.sv
// In-order 2-wide circular issue buffer between decode and the two FU slots.
// Accepts up to two entries per cycle and presents the two oldest entries for issue.
package issue_queue_pkg;
    typedef logic [31:0] issue_data_t;
endpackage

module issue_queue #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = $bits(issue_queue_pkg::issue_data_t)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [1:0]              in_valid,
    input  logic [DATA_W-1:0]       in_data0,
    input  logic [DATA_W-1:0]       in_data1,
    output logic                    in_ready,
    output logic [1:0]              out_valid,
    output logic [DATA_W-1:0]       out_data0,
    output logic [DATA_W-1:0]       out_data1,
    input  logic [1:0]              issue_take,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;

    logic [PW-1:0]     w_head_p1;
    logic [PW-1:0]     w_tail_p1;
    logic              w_wr0_en;
    logic              w_wr1_en;
    logic [DATA_W-1:0] w_wr0_data;
    logic [1:0]        w_n_enq;
    logic [1:0]        w_n_deq;

    always_comb begin
        w_head_p1 = r_head + PW'(1);
        w_tail_p1 = r_tail + PW'(1);
        // Readiness demands room for a full bundle and ignores same-cycle dequeues.
        in_ready  = (r_count <= CW'(DEPTH - 2));
        out_valid = {(r_count >= CW'(2)), (r_count != '0)};
        out_data0 = r_mem[r_head];
        out_data1 = r_mem[w_head_p1];
        count     = r_count;
    end

    always_comb begin
        w_wr0_en   = in_ready && !flush && (in_valid != 2'b00);
        w_wr1_en   = in_ready && !flush && (in_valid == 2'b11);
        // A lone lane1 entry is packed into the tail slot so no hole is left.
        w_wr0_data = in_valid[0] ? in_data0 : in_data1;
        w_n_enq    = w_wr1_en ? 2'd2 : (w_wr0_en ? 2'd1 : 2'd0);
        w_n_deq    = 2'd0;
        if (issue_take[0] && out_valid[0]) begin
            w_n_deq = (issue_take[1] && out_valid[1]) ? 2'd2 : 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr0_en) begin
            r_mem[r_tail] <= w_wr0_data;
        end
        if (w_wr1_en) begin
            r_mem[w_tail_p1] <= in_data1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PW'(w_n_deq);
            r_tail  <= r_tail + PW'(w_n_enq);
            r_count <= r_count + CW'(w_n_enq) - CW'(w_n_deq);
        end
    end

    a_count_max: assert property (@(posedge clk) disable iff (reset)
        r_count <= CW'(DEPTH));
    a_count_no_underflow: assert property (@(posedge clk) disable iff (reset)
        (({1'b0, r_count} + (CW+1)'(w_n_enq)) >= (CW+1)'(w_n_deq)));

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_issue_queue;
    localparam int DEPTH = 8;
    localparam int DW    = 8;

    logic          clk;
    logic          reset;
    logic          flush;
    logic [1:0]    in_valid;
    logic [DW-1:0] in_data0;
    logic [DW-1:0] in_data1;
    logic          in_ready;
    logic [1:0]    out_valid;
    logic [DW-1:0] out_data0;
    logic [DW-1:0] out_data1;
    logic [1:0]    issue_take;
    logic [3:0]    count;

    int n_checks = 0;
    int n_errors = 0;
    bit run_cmp  = 0;

    logic [DW-1:0] model_q[$];

    issue_queue #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_data0   (in_data0),
        .in_data1   (in_data1),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data0  (out_data0),
        .out_data1  (out_data1),
        .issue_take (issue_take),
        .count      (count)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain FIFO of payloads, updated once per clock.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            model_q.delete();
        end else begin
            int sz;
            int ndeq;
            bit rdy;
            sz  = model_q.size();
            rdy = (DEPTH - sz) >= 2;
            if (flush) begin
                model_q.delete();
            end else begin
                ndeq = 0;
                if (issue_take[0] && sz >= 1) ndeq = (issue_take[1] && sz >= 2) ? 2 : 1;
                for (int i = 0; i < ndeq; i++) void'(model_q.pop_front());
                if (rdy) begin
                    if (in_valid[0]) model_q.push_back(in_data0);
                    if (in_valid[1]) model_q.push_back(in_data1);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            int sz;
            sz = model_q.size();
            check("cmp_count", 32'(count), 32'(sz));
            check("cmp_out_valid", 32'(out_valid), {30'd0, sz >= 2, sz >= 1});
            check("cmp_in_ready", 32'(in_ready), 32'((DEPTH - sz) >= 2));
            if (sz >= 1) check("cmp_out_data0", 32'(out_data0), 32'(model_q[0]));
            if (sz >= 2) check("cmp_out_data1", 32'(out_data1), 32'(model_q[1]));
        end
    end

    task automatic cyc(input logic [1:0] v, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic [1:0] take, input logic fl);
        in_valid   = v;
        in_data0   = d0;
        in_data1   = d1;
        issue_take = take;
        flush      = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] seq;
        reset      = 1;
        flush      = 0;
        in_valid   = 2'b00;
        in_data0   = '0;
        in_data1   = '0;
        issue_take = 2'b00;
        #12;
        reset = 0;
        #1;
        run_cmp = 1;
        check("rst_count", 32'(count), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);

        cyc(2'b11, 8'h11, 8'h22, 2'b00, 0);
        check("ab_out_valid", 32'(out_valid), 3);
        check("ab_data0", 32'(out_data0), 32'h11);
        check("ab_data1", 32'(out_data1), 32'h22);
        check("ab_count", 32'(count), 2);
        cyc(2'b00, 0, 0, 2'b00, 1);
        check("flush0_count", 32'(count), 0);

        cyc(2'b11, 8'h01, 8'h02, 2'b00, 0);
        cyc(2'b11, 8'h03, 8'h04, 2'b00, 0);
        cyc(2'b11, 8'h05, 8'h06, 2'b00, 0);
        check("fill3_count", 32'(count), 6);
        check("fill3_in_ready", 32'(in_ready), 1);
        cyc(2'b11, 8'h07, 8'h08, 2'b00, 0);
        check("fill4_count", 32'(count), 8);
        check("fill4_in_ready", 32'(in_ready), 0);
        cyc(2'b11, 8'h99, 8'h99, 2'b00, 0);
        check("full_ign_count", 32'(count), 8);
        check("full_ign_data0", 32'(out_data0), 32'h01);

        cyc(2'b00, 0, 0, 2'b11, 0);
        check("wrap_pre_count", 32'(count), 6);
        check("wrap_pre_data0", 32'(out_data0), 32'h03);
        seq = 8'h20;
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) begin
                cyc(2'b00, 0, 0, 2'b11, 0);
            end else begin
                cyc(2'b11, seq, seq + 8'd1, 2'b00, 0);
                seq = seq + 8'd2;
                check("wrap_count", 32'(count), 6);
            end
        end
        // Five take-pairs removed 0x03..0x08 and 0x20..0x23; 0x24 is now oldest.
        check("wrap_data0", 32'(out_data0), 32'h24);
        check("wrap_data1", 32'(out_data1), 32'h25);

        cyc(2'b00, 0, 0, 2'b00, 1);
        cyc(2'b11, 8'h0A, 8'h0B, 2'b00, 0);
        cyc(2'b01, 8'h0C, 8'h00, 2'b00, 0);
        check("part_count3", 32'(count), 3);
        cyc(2'b00, 0, 0, 2'b01, 0);
        check("part_take01_data0", 32'(out_data0), 32'h0B);
        check("part_take01_count", 32'(count), 2);
        cyc(2'b00, 0, 0, 2'b10, 0);
        check("part_take10_count", 32'(count), 2);
        check("part_take10_data0", 32'(out_data0), 32'h0B);
        cyc(2'b00, 0, 0, 2'b01, 0);
        check("part_cnt1", 32'(count), 1);
        check("part_cnt1_data0", 32'(out_data0), 32'h0C);
        cyc(2'b00, 0, 0, 2'b11, 0);
        check("part_take11_count", 32'(count), 0);
        cyc(2'b10, 8'h00, 8'h3C, 2'b00, 0);
        check("lane1_only_data0", 32'(out_data0), 32'h3C);
        check("lane1_only_count", 32'(count), 1);

        cyc(2'b11, 8'h41, 8'h42, 2'b00, 0);
        cyc(2'b11, 8'h43, 8'h44, 2'b00, 0);
        check("fl_pre_count", 32'(count), 5);
        cyc(2'b11, 8'h45, 8'h46, 2'b11, 1);
        check("fl_count", 32'(count), 0);
        check("fl_out_valid", 32'(out_valid), 0);
        check("fl_in_ready", 32'(in_ready), 1);
        cyc(2'b01, 8'h55, 8'h00, 2'b00, 0);
        check("fl_after_data0", 32'(out_data0), 32'h55);
        check("fl_after_out_valid", 32'(out_valid), 1);

        cyc(2'b11, 8'h61, 8'h62, 2'b00, 0);
        cyc(2'b01, 8'h63, 8'h00, 2'b00, 0);
        cyc(2'b00, 0, 0, 2'b00, 0);
        check("ar_pre_count", 32'(count), 4);
        #2;
        reset = 1;
        #1;
        check("ar_out_valid_async", 32'(out_valid), 0);
        check("ar_count_async", 32'(count), 0);
        @(negedge clk);
        reset = 0;
        @(posedge clk);
        #1;
        check("ar_count_after", 32'(count), 0);
        check("ar_in_ready_after", 32'(in_ready), 1);

        for (int i = 0; i < 3000; i++) begin
            logic [1:0] v;
            logic [1:0] t;
            v = 2'($urandom_range(0, 3));
            t = 2'($urandom_range(0, 3));
            if (i % 400 > 200 && t != 2'b00 && $urandom_range(0, 1) == 1) t = 2'b00;
            cyc(v, 8'($urandom), 8'($urandom), t, ($urandom_range(0, 63) == 0));
        end
        cyc(2'b00, 0, 0, 2'b00, 0);

        run_cmp = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
